bresenham_ray_ctrl: RTL and testbench

//  Sequencer for the bresenham_df ray datapath. Accepts one laser return (magnitude, angle, sensor pose) via valid/ready.

---
 rtl/bresenham_pkg.sv | 25 ++
 rtl/bresenham_ray_ctrl.sv | 126 ++++++++++++
 tb/tb_bresenham_ray_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bresenham_pkg.sv
// Shared types and widths for the bresenham ray sequencer and its datapath.
// The cell record groups everything the occupancy-grid updater receives per step.
package bresenham_pkg;

  localparam int X_IDX_W = 5;
  localparam int Y_IDX_W = 4;
  localparam int WORD_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    EMIT,
    STEP,
    DONE
  } ctrl_state_t;

  typedef struct packed {
    logic [X_IDX_W-1:0] x;
    logic [Y_IDX_W-1:0] y;
    logic               occupied;
    logic               last;
  } cell_t;

endpackage

// File: rtl/bresenham_ray_ctrl.sv
// Ray sequencer: latches one laser return, walks the datapath x register from the
// endpoint back to the sensor and streams one occupancy cell per step.
module bresenham_ray_ctrl
  import bresenham_pkg::*;
#(
  parameter int MAX_STEPS = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ray_valid,
  output logic                ray_ready,
  input  logic [WORD_W-1:0]   ray_magnitude,
  input  logic [WORD_W-1:0]   ray_angle,
  input  logic [WORD_W-1:0]   ray_sensor_x,
  input  logic [WORD_W-1:0]   ray_sensor_y,
  output logic [WORD_W-1:0]   dp_magnitude,
  output logic [WORD_W-1:0]   dp_angle,
  output logic [WORD_W-1:0]   dp_sensor_x,
  output logic [WORD_W-1:0]   dp_sensor_y,
  output logic                dp_x_we,
  output logic                dp_x_source,
  input  logic [X_IDX_W-1:0]  dp_current_x,
  input  logic [X_IDX_W-1:0]  dp_x_index,
  input  logic [Y_IDX_W-1:0]  dp_y_index,
  output logic                cell_valid,
  input  logic                cell_ready,
  output logic [X_IDX_W-1:0]  cell_x,
  output logic [Y_IDX_W-1:0]  cell_y,
  output logic                cell_occupied,
  output logic                cell_last,
  output logic                ray_done
);

  localparam int CNT_W = $clog2(MAX_STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MAX_STEPS - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next;
  logic [CNT_W-1:0]  r_stepCnt;
  cell_t             r_cell;
  logic [WORD_W-1:0] r_magnitude;
  logic [WORD_W-1:0] r_angle;
  logic [WORD_W-1:0] r_sensorX;
  logic [WORD_W-1:0] r_sensorY;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // The last flag is fixed in CAPTURE, so EMIT never lets STEP run with x already at 0.
  always_comb begin
    w_next      = r_state;
    ray_ready   = 1'b0;
    dp_x_we     = 1'b0;
    dp_x_source = 1'b0;
    cell_valid  = 1'b0;
    ray_done    = 1'b0;
    case (r_state)
      IDLE: begin
        ray_ready = 1'b1;
        if (ray_valid) w_next = LOAD;
      end
      LOAD: begin
        dp_x_we = 1'b1;
        w_next  = CAPTURE;
      end
      CAPTURE: w_next = EMIT;
      EMIT: begin
        cell_valid = 1'b1;
        if (cell_ready) w_next = r_cell.last ? DONE : STEP;
      end
      STEP: begin
        dp_x_we     = 1'b1;
        dp_x_source = 1'b1;
        w_next      = CAPTURE;
      end
      DONE: begin
        ray_done = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stepCnt   <= '0;
      r_cell      <= '0;
      r_magnitude <= '0;
      r_angle     <= '0;
      r_sensorX   <= '0;
      r_sensorY   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ray_valid) begin
            r_magnitude <= ray_magnitude;
            r_angle     <= ray_angle;
            r_sensorX   <= ray_sensor_x;
            r_sensorY   <= ray_sensor_y;
            r_stepCnt   <= '0;
          end
        end
        CAPTURE: begin
          r_cell.x        <= dp_x_index;
          r_cell.y        <= dp_y_index;
          r_cell.occupied <= (r_stepCnt == '0);
          r_cell.last     <= (dp_current_x == '0) || (r_stepCnt == LAST_STEP);
        end
        STEP: r_stepCnt <= r_stepCnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign dp_magnitude  = r_magnitude;
  assign dp_angle      = r_angle;
  assign dp_sensor_x   = r_sensorX;
  assign dp_sensor_y   = r_sensorY;
  assign cell_x        = r_cell.x;
  assign cell_y        = r_cell.y;
  assign cell_occupied = r_cell.occupied;
  assign cell_last     = r_cell.last;

endmodule

// File: tb/tb_bresenham_ray_ctrl.sv
// Directed bench for bresenham_ray_ctrl with a tiny datapath stand-in per DUT:
// x register loads magnitude[4:0], index = x + sensor_x[4:0], y = sensor_y[3:0] ^ x[3:0].
module tb_bresenham_ray_ctrl;
  import bresenham_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        rayValidA, rayValidB, cellReady;
  logic [31:0] rayMag, rayAng, raySx, raySy;

  logic        rayReadyA, dpWeA, dpSrcA, cellValidA, cellOccA, cellLastA, rayDoneA;
  logic [31:0] dpMagA, dpAngA, dpSxA, dpSyA;
  logic [4:0]  cellXA, dpXIdxA;
  logic [3:0]  cellYA, dpYIdxA;
  logic [4:0]  mXa = '0;

  logic        rayReadyB, dpWeB, dpSrcB, cellValidB, cellOccB, cellLastB, rayDoneB;
  logic [31:0] dpMagB, dpAngB, dpSxB, dpSyB;
  logic [4:0]  cellXB, dpXIdxB;
  logic [3:0]  cellYB, dpYIdxB;
  logic [4:0]  mXb = '0;

  int total = 0;
  int bad   = 0;

  int          recCycle[$];
  logic [10:0] recCell[$];
  int          doneCycle, readyCycle;
  bit          stallWe, srcSeen, stallChange, dpChanged, zeroSeen;

  always #5 clock = ~clock;

  assign dpXIdxA = mXa + dpSxA[4:0];
  assign dpYIdxA = dpSyA[3:0] ^ mXa[3:0];
  assign dpXIdxB = mXb + dpSxB[4:0];
  assign dpYIdxB = dpSyB[3:0] ^ mXb[3:0];

  always @(posedge clock) begin
    if (dpWeA) mXa <= dpSrcA ? mXa - 5'd1 : dpMagA[4:0];
    if (dpWeB) mXb <= dpSrcB ? mXb - 5'd1 : dpMagB[4:0];
  end

  bresenham_ray_ctrl #(.MAX_STEPS(32)) dutA (
    .clock(clock), .reset(reset), .ray_valid(rayValidA), .ray_ready(rayReadyA),
    .ray_magnitude(rayMag), .ray_angle(rayAng), .ray_sensor_x(raySx), .ray_sensor_y(raySy),
    .dp_magnitude(dpMagA), .dp_angle(dpAngA), .dp_sensor_x(dpSxA), .dp_sensor_y(dpSyA),
    .dp_x_we(dpWeA), .dp_x_source(dpSrcA), .dp_current_x(mXa), .dp_x_index(dpXIdxA),
    .dp_y_index(dpYIdxA), .cell_valid(cellValidA), .cell_ready(cellReady), .cell_x(cellXA),
    .cell_y(cellYA), .cell_occupied(cellOccA), .cell_last(cellLastA), .ray_done(rayDoneA)
  );

  bresenham_ray_ctrl #(.MAX_STEPS(4)) dutB (
    .clock(clock), .reset(reset), .ray_valid(rayValidB), .ray_ready(rayReadyB),
    .ray_magnitude(rayMag), .ray_angle(rayAng), .ray_sensor_x(raySx), .ray_sensor_y(raySy),
    .dp_magnitude(dpMagB), .dp_angle(dpAngB), .dp_sensor_x(dpSxB), .dp_sensor_y(dpSyB),
    .dp_x_we(dpWeB), .dp_x_source(dpSrcB), .dp_current_x(mXb), .dp_x_index(dpXIdxB),
    .dp_y_index(dpYIdxB), .cell_valid(cellValidB), .cell_ready(cellReady), .cell_x(cellXB),
    .cell_y(cellYB), .cell_occupied(cellOccB), .cell_last(cellLastB), .ray_done(rayDoneB)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one ray and records handshakes/flags; cycle 0 is the accepting edge.
  task automatic runRay(input bit sel, input logic [31:0] mag, input logic [31:0] sx,
                        input logic [31:0] sy, input int stallLo, input int stallHi);
    logic [10:0] prevCell, curCell;
    logic        vld, rdy, dn, we, src;
    logic [4:0]  curX;
    logic [31:0] dpm;
    bit          prevStalled = 1'b0;
    int          cyc;
    recCycle.delete(); recCell.delete();
    doneCycle = -1; readyCycle = -1;
    stallWe = 0; srcSeen = 0; stallChange = 0; dpChanged = 0; zeroSeen = 0;
    prevCell = '0;
    rayMag = mag; rayAng = 32'h1234_5678; raySx = sx; raySy = sy;
    cellReady = 1'b1;
    if (sel) rayValidB = 1'b1; else rayValidA = 1'b1;
    tick();
    rayValidA = 1'b0; rayValidB = 1'b0;
    rayMag = 32'hFFFF_FFFF; rayAng = 32'h0; raySx = 32'hAAAA_AAAA; raySy = 32'h5555_5555;
    cyc = 1;
    while (cyc < 200 && readyCycle < 0) begin
      cellReady = !(cyc >= stallLo && cyc <= stallHi);
      curCell = sel ? {cellXB, cellYB, cellOccB, cellLastB} : {cellXA, cellYA, cellOccA, cellLastA};
      vld  = sel ? cellValidB : cellValidA;
      rdy  = sel ? rayReadyB  : rayReadyA;
      dn   = sel ? rayDoneB   : rayDoneA;
      we   = sel ? dpWeB      : dpWeA;
      src  = sel ? dpSrcB     : dpSrcA;
      curX = sel ? mXb        : mXa;
      dpm  = sel ? dpMagB     : dpMagA;
      if (prevStalled && curCell !== prevCell) stallChange = 1;
      prevStalled = vld && !cellReady;
      prevCell = curCell;
      if (vld && cellReady) begin recCycle.push_back(cyc); recCell.push_back(curCell); end
      if (dn) doneCycle = cyc;
      if (!cellReady && we) stallWe = 1;
      if (src) srcSeen = 1;
      if (cyc >= 2 && curX == 5'd0) zeroSeen = 1;
      if (doneCycle < 0 && dpm !== mag) dpChanged = 1;
      if (rdy && doneCycle >= 0) readyCycle = cyc;
      tick();
      cyc++;
    end
    cellReady = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    total++; if (rayReadyA !== 1'b1) begin bad++; $display("FAIL rst_ray_ready got=%b want=1", rayReadyA); end
    total++; if (cellValidA !== 1'b0) begin bad++; $display("FAIL rst_cell_valid got=%b want=0", cellValidA); end
    total++; if ({cellXA, cellYA, cellOccA, cellLastA} !== 11'd0) begin bad++; $display("FAIL rst_cell got=%h want=000", {cellXA, cellYA, cellOccA, cellLastA}); end
    total++; if ({dpWeA, dpSrcA, rayDoneA} !== 3'b000) begin bad++; $display("FAIL rst_ctrl got=%b want=000", {dpWeA, dpSrcA, rayDoneA}); end
    total++; if ({dpMagA, dpAngA, dpSxA, dpSyA} !== 128'd0) begin bad++; $display("FAIL rst_ray_regs got=%h want=0", {dpMagA, dpAngA, dpSxA, dpSyA}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_ray();
    logic [10:0] expC [4];
    int          expT [4];
    logic [10:0] got;
    int          gotT;
    expC = '{{5'd5, 4'd2, 2'b10}, {5'd4, 4'd3, 2'b00}, {5'd3, 4'd0, 2'b00}, {5'd2, 4'd1, 2'b01}};
    expT = '{3, 6, 9, 12};
    runRay(1'b0, 32'd3, 32'd2, 32'd1, -1, -1);
    total++; if (recCell.size() != 4) begin bad++; $display("FAIL t1_count got=%0d want=4", recCell.size()); end
    for (int i = 0; i < 4; i++) begin
      got = 11'h7FF; gotT = -1;
      if (i < recCell.size()) begin got = recCell[i]; gotT = recCycle[i]; end
      total++; if (got !== expC[i]) begin bad++; $display("FAIL t1_cell%0d got=%h want=%h", i, got, expC[i]); end
      total++; if (gotT != expT[i]) begin bad++; $display("FAIL t1_cycle%0d got=%0d want=%0d", i, gotT, expT[i]); end
    end
    total++; if (doneCycle != 13) begin bad++; $display("FAIL t1_done got=%0d want=13", doneCycle); end
    total++; if (readyCycle != 14) begin bad++; $display("FAIL t1_ready got=%0d want=14", readyCycle); end
    total++; if (dpChanged !== 1'b0) begin bad++; $display("FAIL t1_dp_stable got=%b want=0", dpChanged); end
    total++; if ({dpAngA, dpSxA} !== {32'h1234_5678, 32'd2}) begin bad++; $display("FAIL t1_dp_words got=%h want=1234567800000002", {dpAngA, dpSxA}); end
  endtask

  task automatic test_stall();
    logic [10:0] expC [4];
    int          expT [4];
    logic [10:0] got;
    int          gotT;
    expC = '{{5'd5, 4'd2, 2'b10}, {5'd4, 4'd3, 2'b00}, {5'd3, 4'd0, 2'b00}, {5'd2, 4'd1, 2'b01}};
    expT = '{8, 11, 14, 17};
    runRay(1'b0, 32'd3, 32'd2, 32'd1, 3, 7);
    for (int i = 0; i < 4; i++) begin
      got = 11'h7FF; gotT = -1;
      if (i < recCell.size()) begin got = recCell[i]; gotT = recCycle[i]; end
      total++; if (got !== expC[i]) begin bad++; $display("FAIL t2_cell%0d got=%h want=%h", i, got, expC[i]); end
      total++; if (gotT != expT[i]) begin bad++; $display("FAIL t2_cycle%0d got=%0d want=%0d", i, gotT, expT[i]); end
    end
    total++; if (stallWe !== 1'b0) begin bad++; $display("FAIL t2_we_in_stall got=%b want=0", stallWe); end
    total++; if (stallChange !== 1'b0) begin bad++; $display("FAIL t2_cell_stable got=%b want=0", stallChange); end
    total++; if (doneCycle != 18) begin bad++; $display("FAIL t2_done got=%0d want=18", doneCycle); end
  endtask

  task automatic test_zero_length();
    logic [10:0] got;
    runRay(1'b0, 32'd0, 32'd7, 32'd9, -1, -1);
    got = 11'h7FF;
    if (recCell.size() > 0) got = recCell[0];
    total++; if (recCell.size() != 1) begin bad++; $display("FAIL t3_count got=%0d want=1", recCell.size()); end
    total++; if (got !== {5'd7, 4'd9, 2'b11}) begin bad++; $display("FAIL t3_cell got=%h want=%h", got, {5'd7, 4'd9, 2'b11}); end
    total++; if (doneCycle != 4) begin bad++; $display("FAIL t3_done got=%0d want=4", doneCycle); end
    total++; if (readyCycle != 5) begin bad++; $display("FAIL t3_ready got=%0d want=5", readyCycle); end
    total++; if (srcSeen !== 1'b0) begin bad++; $display("FAIL t3_x_source got=%b want=0", srcSeen); end
  endtask

  task automatic test_truncate();
    logic [10:0] expC [4];
    logic [10:0] got;
    expC = '{{5'd10, 4'd10, 2'b10}, {5'd9, 4'd9, 2'b00}, {5'd8, 4'd8, 2'b00}, {5'd7, 4'd7, 2'b01}};
    runRay(1'b1, 32'd10, 32'd0, 32'd0, -1, -1);
    total++; if (recCell.size() != 4) begin bad++; $display("FAIL t4_count got=%0d want=4", recCell.size()); end
    for (int i = 0; i < 4; i++) begin
      got = 11'h7FF;
      if (i < recCell.size()) got = recCell[i];
      total++; if (got !== expC[i]) begin bad++; $display("FAIL t4_cell%0d got=%h want=%h", i, got, expC[i]); end
    end
    total++; if (zeroSeen !== 1'b0) begin bad++; $display("FAIL t4_x_zero got=%b want=0", zeroSeen); end
    total++; if (doneCycle != 13) begin bad++; $display("FAIL t4_done got=%0d want=13", doneCycle); end
    total++; if (dpAngB !== 32'h1234_5678) begin bad++; $display("FAIL t4_angle got=%h want=12345678", dpAngB); end
  endtask

  task automatic test_reset_mid_ray();
    bit          sawActivity = 1'b0;
    logic [10:0] got;
    rayMag = 32'd3; rayAng = 32'h1234_5678; raySx = 32'd2; raySy = 32'd1;
    cellReady = 1'b1;
    rayValidA = 1'b1;
    tick();
    rayValidA = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    reset = 1'b1;
    tick();
    total++; if (rayReadyA !== 1'b1) begin bad++; $display("FAIL t5_ready got=%b want=1", rayReadyA); end
    total++; if ({cellValidA, rayDoneA} !== 2'b00) begin bad++; $display("FAIL t5_valid_done got=%b want=00", {cellValidA, rayDoneA}); end
    total++; if ({cellXA, cellYA, cellOccA, cellLastA, dpMagA} !== 43'd0) begin bad++; $display("FAIL t5_regs got=%h want=0", {cellXA, cellYA, cellOccA, cellLastA, dpMagA}); end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rayDoneA || cellValidA) sawActivity = 1'b1;
      tick();
    end
    total++; if (sawActivity !== 1'b0) begin bad++; $display("FAIL t5_quiet got=%b want=0", sawActivity); end
    runRay(1'b0, 32'd3, 32'd2, 32'd1, -1, -1);
    got = 11'h7FF;
    if (recCell.size() > 0) got = recCell[0];
    total++; if (recCell.size() != 4 || got !== {5'd5, 4'd2, 2'b10}) begin bad++; $display("FAIL t5_rerun got=%0d/%h want=4/%h", recCell.size(), got, {5'd5, 4'd2, 2'b10}); end
    total++; if (doneCycle != 13) begin bad++; $display("FAIL t5_rerun_done got=%0d want=13", doneCycle); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] expC [6];
    int          expT [6];
    int          hsT[$];
    logic [10:0] hsC[$];
    int          doneT[$];
    int          acceptCyc = -1;
    int          gotDone;
    bit          dpBad = 1'b0;
    logic [10:0] got;
    int          gotT;
    expC = '{{5'd5, 4'd2, 2'b10}, {5'd4, 4'd3, 2'b00}, {5'd3, 4'd0, 2'b00}, {5'd2, 4'd1, 2'b01},
             {5'd11, 4'd5, 2'b10}, {5'd10, 4'd4, 2'b01}};
    expT = '{3, 6, 9, 12, 17, 20};
    cellReady = 1'b1;
    rayMag = 32'd3; rayAng = 32'h1234_5678; raySx = 32'd2; raySy = 32'd1;
    rayValidA = 1'b1;
    tick();
    rayMag = 32'd1; raySx = 32'd10; raySy = 32'd4;
    for (int cyc = 1; cyc < 30; cyc++) begin
      if (cyc <= 13 && dpMagA !== 32'd3) dpBad = 1'b1;
      if (cellValidA && cellReady) begin hsT.push_back(cyc); hsC.push_back({cellXA, cellYA, cellOccA, cellLastA}); end
      if (rayDoneA) doneT.push_back(cyc);
      if (rayReadyA && acceptCyc < 0) acceptCyc = cyc;
      tick();
      if (acceptCyc >= 0) rayValidA = 1'b0;
    end
    rayValidA = 1'b0;
    total++; if (dpBad !== 1'b0) begin bad++; $display("FAIL t6_first_dp got=%b want=0", dpBad); end
    total++; if (acceptCyc != 14) begin bad++; $display("FAIL t6_accept got=%0d want=14", acceptCyc); end
    gotDone = -1; if (doneT.size() > 1) gotDone = doneT[1];
    total++; if (doneT.size() != 2 || doneT[0] != 13 || gotDone != 21) begin bad++; $display("FAIL t6_done got=%0d/%0d want=2/21", doneT.size(), gotDone); end
    for (int i = 0; i < 6; i++) begin
      got = 11'h7FF; gotT = -1;
      if (i < hsC.size()) begin got = hsC[i]; gotT = hsT[i]; end
      total++; if (got !== expC[i] || gotT != expT[i]) begin bad++; $display("FAIL t6_cell%0d got=%h@%0d want=%h@%0d", i, got, gotT, expC[i], expT[i]); end
    end
    total++; if (dpMagA !== 32'd1) begin bad++; $display("FAIL t6_second_dp got=%0d want=1", dpMagA); end
  endtask

  initial begin
    rayValidA = 1'b0; rayValidB = 1'b0; cellReady = 1'b1;
    rayMag = '0; rayAng = '0; raySx = '0; raySy = '0;
    test_reset();
    test_basic_ray();
    tick();
    test_stall();
    tick();
    test_zero_length();
    tick();
    test_truncate();
    tick();
    test_reset_mid_ray();
    tick();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
